// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared codes and constants for the execute stage
package exe_stage_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SAL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_XOR  = 4'd11;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  localparam logic [2:0] ST_SW   = 3'd0;
  localparam logic [2:0] ST_SB   = 3'd1;
  localparam logic [2:0] ST_SH   = 3'd2;
  localparam logic [2:0] ST_SWL  = 3'd3;
  localparam logic [2:0] ST_SWR  = 3'd4;
  localparam logic [2:0] ST_NONE = 3'd7;

  localparam logic [2:0] LT_NONE = 3'd7;

  localparam logic [5:0] REG_RA = 6'd31;
  localparam logic [5:0] REG_LO = 6'd32;
  localparam logic [5:0] REG_HI = 6'd33;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/exe_divider.sv
// rtl/exe_divider.sv - iterative restoring divider, one quotient bit per cycle
module exe_divider
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rem_q, quo_q, dvsr_q, dividend_q;
  logic             q_neg_q, r_neg_q, zero_q;

  logic [32:0]      shift;
  logic [31:0]      diff, rem_nx, quo_nx;
  logic             ge;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      DIV_IDLE: if (start_i) state_d = DIV_RUN;
      DIV_RUN: begin
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          done_o  = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign busy_o = (state_q == DIV_RUN);

  // Partial remainder never exceeds twice the divisor, so a 32-bit difference is exact.
  assign shift  = {rem_q, quo_q[31]};
  assign ge     = (shift >= {1'b0, dvsr_q});
  assign diff   = shift[31:0] - dvsr_q;
  assign rem_nx = ge ? diff : shift[31:0];
  assign quo_nx = {quo_q[30:0], ge};

  assign quotient_o  = zero_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_nx : quo_nx);
  assign remainder_o = zero_q ? dividend_q    : (r_neg_q ? -rem_nx : rem_nx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dividend_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state_q == DIV_IDLE) begin
      if (start_i) begin
        cnt_q      <= '0;
        rem_q      <= '0;
        quo_q      <= (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
        dvsr_q     <= (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
        dividend_q <= dividend_i;
        q_neg_q    <= signed_i && (dividend_i[31] ^ divisor_i[31]);
        r_neg_q    <= signed_i && dividend_i[31];
        zero_q     <= (divisor_i == 32'd0);
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: ALU, store alignment, mult/div, HI/LO write
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  de_aluop,
  input  logic [31:0] de_alusrc1,
  input  logic [31:0] de_alusrc2,
  input  logic        de_mult_en,
  input  logic        de_div_en,
  input  logic        de_is_signed,
  input  logic [31:0] de_MD_src1,
  input  logic [31:0] de_MD_src2,
  input  logic [2:0]  de_store_type,
  input  logic        de_mem_en,
  input  logic        de_mem_read,
  input  logic        de_reg_en,
  input  logic [5:0]  de_reg_waddr,
  input  logic [2:0]  de_load_type,
  input  logic [31:0] de_store_rt_data,
  input  logic [31:0] de_load_rt_data,
  output logic        ex_busy,
  output logic [31:0] ex_alu_result,
  output logic        ex_mem_en,
  output logic        ex_mem_read,
  output logic        ex_reg_en,
  output logic [3:0]  ex_mem_wen,
  output logic [31:0] ex_mem_wdata,
  output logic [5:0]  ex_reg_waddr,
  output logic [2:0]  ex_load_type,
  output logic [31:0] ex_load_rt_data,
  output logic        ex_hilo_we,
  output logic [31:0] ex_hi_data,
  output logic [31:0] ex_lo_data
);

  logic [31:0] alu_res;
  logic [1:0]  off;
  logic [3:0]  wen_raw;
  logic [31:0] wdata_d;
  logic        store_act;
  logic [63:0] mul_a, mul_b, product;
  logic        mult_go;
  logic        div_done;
  logic [31:0] div_quo, div_rem;
  logic        hilo_we_d;
  logic [31:0] hi_d, lo_d;

  logic [31:0] alu_q, wdata_q, load_rt_q, hi_q, lo_q;
  logic [3:0]  wen_q;
  logic [5:0]  waddr_q;
  logic [2:0]  load_type_q;
  logic        mem_en_q, mem_read_q, reg_en_q, hilo_we_q;

  always_comb begin
    alu_res = 32'd0;
    case (de_aluop)
      ALU_AND:          alu_res = de_alusrc1 & de_alusrc2;
      ALU_OR:           alu_res = de_alusrc1 | de_alusrc2;
      ALU_ADD:          alu_res = de_alusrc1 + de_alusrc2;
      ALU_SUB:          alu_res = de_alusrc1 - de_alusrc2;
      ALU_SLT:          alu_res = {31'd0, $signed(de_alusrc1) < $signed(de_alusrc2)};
      ALU_SLTU:         alu_res = {31'd0, de_alusrc1 < de_alusrc2};
      ALU_SLL, ALU_SAL: alu_res = de_alusrc2 << de_alusrc1[4:0];
      ALU_SRL:          alu_res = de_alusrc2 >> de_alusrc1[4:0];
      ALU_SRA:          alu_res = 32'($signed(de_alusrc2) >>> de_alusrc1[4:0]);
      ALU_LUI:          alu_res = {de_alusrc2[15:0], 16'h0};
      ALU_XOR:          alu_res = de_alusrc1 ^ de_alusrc2;
      ALU_NOR:          alu_res = ~(de_alusrc1 | de_alusrc2);
      default:          alu_res = 32'd0;
    endcase
  end

  assign off       = alu_res[1:0];
  assign store_act = de_mem_en && !de_mem_read && (de_store_type != ST_NONE);

  always_comb begin
    wen_raw = 4'b0000;
    wdata_d = de_store_rt_data;
    case (de_store_type)
      ST_SW: wen_raw = 4'b1111;
      ST_SB: begin
        wen_raw = 4'b0001 << off;
        wdata_d = {4{de_store_rt_data[7:0]}};
      end
      ST_SH: begin
        wen_raw = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{de_store_rt_data[15:0]}};
      end
      ST_SWL: begin
        wen_raw = 4'b1111 >> (2'd3 - off);
        wdata_d = de_store_rt_data >> {2'd3 - off, 3'b000};
      end
      ST_SWR: begin
        wen_raw = 4'b1111 << off;
        wdata_d = de_store_rt_data << {off, 3'b000};
      end
      default: wen_raw = 4'b0000;
    endcase
  end

  // Sign-extend only for signed multiply so one 64-bit multiplier serves both forms.
  assign mul_a   = {{32{de_is_signed & de_MD_src1[31]}}, de_MD_src1};
  assign mul_b   = {{32{de_is_signed & de_MD_src2[31]}}, de_MD_src2};
  assign product = mul_a * mul_b;
  assign mult_go = de_mult_en && !ex_busy;

  exe_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (de_div_en),
    .signed_i    (de_is_signed),
    .dividend_i  (de_MD_src1),
    .divisor_i   (de_MD_src2),
    .busy_o      (ex_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    hilo_we_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (div_done) begin
      hilo_we_d = 1'b1;
      hi_d      = div_rem;
      lo_d      = div_quo;
    end else if (mult_go) begin
      hilo_we_d = 1'b1;
      hi_d      = product[63:32];
      lo_d      = product[31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_en_q    <= 1'b0;
      wen_q       <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      load_type_q <= LT_NONE;
      load_rt_q   <= '0;
      hilo_we_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      alu_q       <= alu_res;
      mem_en_q    <= de_mem_en && !ex_busy;
      mem_read_q  <= de_mem_read;
      reg_en_q    <= de_reg_en && !ex_busy;
      wen_q       <= (store_act && !ex_busy) ? wen_raw : 4'b0000;
      wdata_q     <= wdata_d;
      waddr_q     <= de_reg_waddr;
      load_type_q <= de_load_type;
      load_rt_q   <= de_load_rt_data;
      hilo_we_q   <= hilo_we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign ex_alu_result   = alu_q;
  assign ex_mem_en       = mem_en_q;
  assign ex_mem_read     = mem_read_q;
  assign ex_reg_en       = reg_en_q;
  assign ex_mem_wen      = wen_q;
  assign ex_mem_wdata    = wdata_q;
  assign ex_reg_waddr    = waddr_q;
  assign ex_load_type    = load_type_q;
  assign ex_load_rt_data = load_rt_q;
  assign ex_hilo_we      = hilo_we_q;
  assign ex_hi_data      = hi_q;
  assign ex_lo_data      = lo_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  de_aluop;
  logic [31:0] de_alusrc1, de_alusrc2;
  logic        de_mult_en, de_div_en, de_is_signed;
  logic [31:0] de_MD_src1, de_MD_src2;
  logic [2:0]  de_store_type;
  logic        de_mem_en, de_mem_read, de_reg_en;
  logic [5:0]  de_reg_waddr;
  logic [2:0]  de_load_type;
  logic [31:0] de_store_rt_data, de_load_rt_data;
  logic        ex_busy;
  logic [31:0] ex_alu_result;
  logic        ex_mem_en, ex_mem_read, ex_reg_en;
  logic [3:0]  ex_mem_wen;
  logic [31:0] ex_mem_wdata;
  logic [5:0]  ex_reg_waddr;
  logic [2:0]  ex_load_type;
  logic [31:0] ex_load_rt_data;
  logic        ex_hilo_we;
  logic [31:0] ex_hi_data, ex_lo_data;

  exe_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn),
    .de_aluop(de_aluop), .de_alusrc1(de_alusrc1), .de_alusrc2(de_alusrc2),
    .de_mult_en(de_mult_en), .de_div_en(de_div_en), .de_is_signed(de_is_signed),
    .de_MD_src1(de_MD_src1), .de_MD_src2(de_MD_src2),
    .de_store_type(de_store_type), .de_mem_en(de_mem_en), .de_mem_read(de_mem_read),
    .de_reg_en(de_reg_en), .de_reg_waddr(de_reg_waddr), .de_load_type(de_load_type),
    .de_store_rt_data(de_store_rt_data), .de_load_rt_data(de_load_rt_data),
    .ex_busy(ex_busy), .ex_alu_result(ex_alu_result),
    .ex_mem_en(ex_mem_en), .ex_mem_read(ex_mem_read), .ex_reg_en(ex_reg_en),
    .ex_mem_wen(ex_mem_wen), .ex_mem_wdata(ex_mem_wdata),
    .ex_reg_waddr(ex_reg_waddr), .ex_load_type(ex_load_type),
    .ex_load_rt_data(ex_load_rt_data), .ex_hilo_we(ex_hilo_we),
    .ex_hi_data(ex_hi_data), .ex_lo_data(ex_lo_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [12:0] ctrl;
    logic [31:0] load_rt;
  } exp_t;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  exp_t  exp_q[$];
  hilo_t hilo_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    de_aluop = 4'd0; de_alusrc1 = '0; de_alusrc2 = '0;
    de_mult_en = 1'b0; de_div_en = 1'b0; de_is_signed = 1'b0;
    de_MD_src1 = '0; de_MD_src2 = '0;
    de_store_type = 3'd7; de_mem_en = 1'b0; de_mem_read = 1'b0; de_reg_en = 1'b0;
    de_reg_waddr = '0; de_load_type = 3'd7;
    de_store_rt_data = '0; de_load_rt_data = '0;
  endtask

  // Each HI/LO write pulse must match the oldest outstanding mult/div expectation.
  always @(negedge clk) begin
    if (ex_hilo_we) begin
      if (hilo_q.size() == 0) begin
        check("hilo_we_unexpected", ex_hilo_we, 1'b0);
      end else begin
        hilo_t h;
        h = hilo_q.pop_front();
        check({h.tag, "_hi"}, ex_hi_data, h.hi);
        check({h.tag, "_lo"}, ex_lo_data, h.lo);
      end
    end
  end

  task automatic alu_step(input string tag, input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [2:0] st, input logic mem_en,
                          input logic mem_rd, input logic [31:0] rt,
                          input logic [31:0] e_alu, input logic [3:0] e_wen,
                          input logic [31:0] e_wdata);
    exp_t e, g;
    @(negedge clk);
    de_aluop = op; de_alusrc1 = s1; de_alusrc2 = s2;
    de_store_type = st; de_mem_en = mem_en; de_mem_read = mem_rd;
    de_store_rt_data = rt; de_reg_en = !mem_en || mem_rd;
    de_reg_waddr = 6'(tests_run); de_load_type = mem_rd ? 3'd0 : 3'd7;
    de_load_rt_data = ~rt;
    e.tag = tag; e.alu = e_alu; e.wen = e_wen; e.wdata = e_wdata;
    e.ctrl = {!mem_en || mem_rd, mem_en, mem_rd, 6'(tests_run), (mem_rd ? 3'd0 : 3'd7), 1'b0};
    e.load_rt = ~rt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({g.tag, "_alu"}, ex_alu_result, g.alu);
    if (mem_en) begin
      check({g.tag, "_wen"}, ex_mem_wen, g.wen);
      if (g.wen != 4'b0000) check({g.tag, "_wdata"}, ex_mem_wdata, g.wdata);
    end
    check({g.tag, "_ctrl"},
          {ex_reg_en, ex_mem_en, ex_mem_read, ex_reg_waddr, ex_load_type, 1'b0}, g.ctrl);
    check({g.tag, "_ldrt"}, ex_load_rt_data, g.load_rt);
  endtask

  task automatic mult_step(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    hilo_t h;
    @(negedge clk);
    clear_inputs();
    de_mult_en = 1'b1; de_is_signed = sgn; de_MD_src1 = a; de_MD_src2 = b;
    h.tag = tag; h.hi = e_hi; h.lo = e_lo;
    hilo_q.push_back(h);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic div_step(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    hilo_t h;
    int busy_cnt;
    logic bad;
    h.tag = tag; h.hi = e_hi; h.lo = e_lo;
    hilo_q.push_back(h);
    @(negedge clk);
    clear_inputs();
    de_div_en = 1'b1; de_is_signed = sgn; de_MD_src1 = a; de_MD_src2 = b;
    @(negedge clk);
    de_div_en = 1'b0;
    de_reg_en = 1'b1; de_mem_en = 1'b1; de_store_type = 3'd0;
    busy_cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (ex_busy) begin
        busy_cnt++;
        if (i > 0 && (ex_reg_en || ex_mem_en || ex_mem_wen != 4'b0000)) bad = 1'b1;
      end
      if (!ex_busy) break;
      de_mult_en = (i == 5);
      de_div_en  = (i == 5);
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_bubbles"}, bad, 1'b0);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu", ex_alu_result, 32'd0);
    check("rst_ctrl", {ex_busy, ex_mem_en, ex_mem_read, ex_reg_en, ex_mem_wen, ex_hilo_we}, 9'd0);
    check("rst_load_type", ex_load_type, 3'd7);
    check("rst_hilo", {ex_hi_data, ex_lo_data}, 64'd0);
    resetn = 1'b1;

    alu_step("add_wrap", 4'd2, 32'h7FFF_FFFF, 32'h1, 3'd7, 1'b0, 1'b0, 0, 32'h8000_0000, 0, 0);
    alu_step("sra",      4'd9, 32'h4, 32'hF000_0000, 3'd7, 1'b0, 1'b0, 0, 32'hFF00_0000, 0, 0);
    alu_step("srl",      4'd7, 32'h24, 32'hF000_0000, 3'd7, 1'b0, 1'b0, 0, 32'h0F00_0000, 0, 0);
    alu_step("sal",      4'd8, 32'h4, 32'h1, 3'd7, 1'b0, 1'b0, 0, 32'h10, 0, 0);
    alu_step("sub",      4'd3, 32'h0, 32'h1, 3'd7, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 0, 0);
    alu_step("slt",      4'd4, 32'hFFFF_FFFF, 32'h1, 3'd7, 1'b0, 1'b0, 0, 32'h1, 0, 0);
    alu_step("sltu",     4'd5, 32'hFFFF_FFFF, 32'h1, 3'd7, 1'b0, 1'b0, 0, 32'h0, 0, 0);
    alu_step("lui",      4'd10, 32'h0, 32'hABCD_1234, 3'd7, 1'b0, 1'b0, 0, 32'h1234_0000, 0, 0);
    alu_step("nor",      4'd12, 32'h0F0F_0000, 32'h0000_00F0, 3'd7, 1'b0, 1'b0, 0, 32'hF0F0_FF0F, 0, 0);
    alu_step("undef_op", 4'd13, 32'h1234, 32'h5678, 3'd7, 1'b0, 1'b0, 0, 32'h0, 0, 0);

    alu_step("sb_off3",  4'd2, 32'h1000, 32'h3, 3'd1, 1'b1, 1'b0, 32'h1234_5678,
             32'h1003, 4'b1000, 32'h7878_7878);
    alu_step("sh_off2",  4'd2, 32'h1000, 32'h2, 3'd2, 1'b1, 1'b0, 32'h1234_5678,
             32'h1002, 4'b1100, 32'h5678_5678);
    alu_step("sw",       4'd2, 32'h1000, 32'h0, 3'd0, 1'b1, 1'b0, 32'hDEAD_BEEF,
             32'h1000, 4'b1111, 32'hDEAD_BEEF);
    alu_step("swl_off1", 4'd2, 32'h1000, 32'h1, 3'd3, 1'b1, 1'b0, 32'hAABB_CCDD,
             32'h1001, 4'b0011, 32'h0000_AABB);
    alu_step("swl_off3", 4'd2, 32'h1000, 32'h3, 3'd3, 1'b1, 1'b0, 32'hAABB_CCDD,
             32'h1003, 4'b1111, 32'hAABB_CCDD);
    alu_step("swr_off2", 4'd2, 32'h1000, 32'h2, 3'd4, 1'b1, 1'b0, 32'hAABB_CCDD,
             32'h1002, 4'b1100, 32'hCCDD_0000);
    alu_step("swr_off0", 4'd2, 32'h1000, 32'h0, 3'd4, 1'b1, 1'b0, 32'hAABB_CCDD,
             32'h1000, 4'b1111, 32'hAABB_CCDD);
    alu_step("load_nowen", 4'd2, 32'h1000, 32'h0, 3'd0, 1'b1, 1'b1, 32'h1,
             32'h1000, 4'b0000, 32'h0);

    mult_step("mult",  1'b1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mult_step("multu", 1'b0, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA);

    div_step("div",   1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    div_step("divu0", 1'b0, 32'h7, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
    div_step("divu",  1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

    @(negedge clk);
    clear_inputs();
    de_div_en = 1'b1; de_MD_src1 = 32'd1000; de_MD_src2 = 32'd3;
    @(negedge clk);
    clear_inputs();
    repeat (9) @(negedge clk);
    check("busy_before_reset", ex_busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("busy_async_reset", ex_busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_alu", ex_alu_result, 32'd0);
    check("post_rst_ctrl", {ex_busy, ex_mem_en, ex_reg_en, ex_mem_wen, ex_mem_wdata}, 39'd0);
    check("post_rst_hilo", {ex_hilo_we, ex_hi_data, ex_lo_data}, 65'd0);
    check("post_rst_load_type", ex_load_type, 3'd7);
    check("hilo_pending", 64'(hilo_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
